fetch_pc_gen: RTL and testbench

Fetch-stage program-counter generator with an integrated direct-mapped branch target buffer (BTB). It drives the instruction-memory address that the branch predictor also consumes. It combines the predictor's taken decision with a BTB hit to steer fetch. It applies misprediction redirects from the ALU stage and trains the BTB with resolved taken branches.

---
 rtl/fetch_pc_gen_if.sv | 66 ++++++
 rtl/fetch_pc_gen.sv | 156 +++++++++++++++
 tb/tb_fetch_pc_gen.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_gen_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen_if
//
// Purpose:
//   Bundles the control, resolution and fetch-address signals exchanged
//   between the fetch PC generator and the rest of the pipeline. All
//   addresses are 22-bit word addresses.
//
// Signals:
//   i_Stall         hold the fetch PC (memory or hazard stall)
//   i_BP_taken      predictor taken decision for the current fetch address
//   i_Flush         misprediction redirect request
//   i_ALU_isbranch  ALU-stage instruction is a resolved branch
//   i_ALU_outcome   resolved direction (1 = taken)
//   i_ALU_pc        word address of the resolved branch
//   i_ALU_target    resolved taken target
//   o_IMEM_address  registered fetch PC
//   o_pred_taken    fetch steered to the BTB target this cycle
//   o_pred_target   BTB target for o_IMEM_address (0 on a miss)
//   o_valid         o_IMEM_address is a live fetch
//
// Modports:
//   master  the fetch PC generator (drives the fetch address bus)
//   slave   the surrounding pipeline (predictor, ALU stage, instruction memory)
// -----------------------------------------------------------------------------
interface fetch_pc_gen_if;
    logic        i_Stall;
    logic        i_BP_taken;
    logic        i_Flush;
    logic        i_ALU_isbranch;
    logic        i_ALU_outcome;
    logic [21:0] i_ALU_pc;
    logic [21:0] i_ALU_target;
    logic [21:0] o_IMEM_address;
    logic        o_pred_taken;
    logic [21:0] o_pred_target;
    logic        o_valid;

    modport master (
        input  i_Stall,
        input  i_BP_taken,
        input  i_Flush,
        input  i_ALU_isbranch,
        input  i_ALU_outcome,
        input  i_ALU_pc,
        input  i_ALU_target,
        output o_IMEM_address,
        output o_pred_taken,
        output o_pred_target,
        output o_valid
    );

    modport slave (
        output i_Stall,
        output i_BP_taken,
        output i_Flush,
        output i_ALU_isbranch,
        output i_ALU_outcome,
        output i_ALU_pc,
        output i_ALU_target,
        input  o_IMEM_address,
        input  o_pred_taken,
        input  o_pred_target,
        input  o_valid
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen
//
// Purpose:
//   Fetch-stage program-counter generator with a direct-mapped branch target
//   buffer (BTB). The registered PC drives instruction memory and the branch
//   predictor. A BTB hit combined with the predictor's taken decision steers
//   the next fetch to the stored target; ALU-stage misprediction flushes
//   redirect fetch; resolved taken branches train the BTB.
//
// Parameters:
//   BTB_ENTRIES  number of BTB entries (power of two, 2..256)
//   RESET_PC     word address loaded into the PC on reset
//
// Ports:
//   i_Clk    clock, all state changes on the rising edge
//   i_Reset  synchronous active-high reset
//   bus      fetch_pc_gen_if.master (see interface file for signal list)
//
// Build option:
//   FETCH_BTB_INVALIDATE_EN  when defined, a not-taken resolution whose PC
//                            hits the BTB clears that entry's valid bit.
//                            When undefined, not-taken resolutions leave the
//                            BTB untouched.
//
// Next-PC priority (highest first): reset, flush (only with a resolved
// branch), stall, predicted-taken, sequential PC + 1 (wraps mod 2^22).
// -----------------------------------------------------------------------------
module fetch_pc_gen #(
    parameter int          BTB_ENTRIES = 16,
    parameter logic [21:0] RESET_PC    = 22'h000000
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    fetch_pc_gen_if.master    bus
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 22 - IDX;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [21:0]            pc_reg;
    logic [21:0]            pc_next;
    logic                   valid_reg;

    // Valid bits live in flops so reset can clear them in one edge; tags
    // and targets sit in plain arrays with no reset (contents are don't-care
    // while the valid bit is low).
    logic [BTB_ENTRIES-1:0] btb_valid_reg;
    logic [TAG_W-1:0]       btb_tag_mem    [BTB_ENTRIES];
    logic [21:0]            btb_target_mem [BTB_ENTRIES];

    // ------------------------------------------------------------------
    // Lookup on the current fetch PC. This read is asynchronous on purpose:
    // the prediction must be available in the same cycle as the address so
    // that a taken prediction redirects on the very next edge. A write on
    // the same edge is not forwarded; the lookup sees the old contents.
    // ------------------------------------------------------------------
    logic [IDX-1:0]   rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_hit;
    logic [21:0]      rd_target;
    logic             pred_taken;

    assign rd_idx     = pc_reg[IDX-1:0];
    assign rd_tag     = pc_reg[21:IDX];
    assign rd_hit     = btb_valid_reg[rd_idx] && (btb_tag_mem[rd_idx] == rd_tag);
    assign rd_target  = rd_hit ? btb_target_mem[rd_idx] : 22'd0;
    assign pred_taken = rd_hit && bus.i_BP_taken && !bus.i_Stall;

    // ------------------------------------------------------------------
    // Training port, addressed by the resolved branch PC.
    // ------------------------------------------------------------------
    logic [IDX-1:0]   wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_en;
    logic             inv_en;

    assign wr_idx = bus.i_ALU_pc[IDX-1:0];
    assign wr_tag = bus.i_ALU_pc[21:IDX];
    // A reset edge drops any pending training write.
    assign wr_en  = bus.i_ALU_isbranch && bus.i_ALU_outcome && !i_Reset;

`ifdef FETCH_BTB_INVALIDATE_EN
    // Not-taken resolution of a branch that currently owns its entry:
    // retire the entry so the stale target stops steering fetch.
    assign inv_en = bus.i_ALU_isbranch && !bus.i_ALU_outcome && !i_Reset &&
                    btb_valid_reg[wr_idx] && (btb_tag_mem[wr_idx] == wr_tag);
`else
    assign inv_en = 1'b0;
`endif

    // One valid flop per entry.
    for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_btb_valid
        always_ff @(posedge i_Clk) begin
            if (i_Reset) begin
                btb_valid_reg[gi] <= 1'b0;
            end else if (wr_en && (wr_idx == IDX'(gi))) begin
                btb_valid_reg[gi] <= 1'b1;
            end else if (inv_en && (wr_idx == IDX'(gi))) begin
                btb_valid_reg[gi] <= 1'b0;
            end
        end
    end

    // Tag/target storage: a same-tag write refreshes the target, a
    // different-tag write replaces the entry -- both are the same write.
    always_ff @(posedge i_Clk) begin
        if (wr_en) begin
            btb_tag_mem[wr_idx]    <= wr_tag;
            btb_target_mem[wr_idx] <= bus.i_ALU_target;
        end
    end

    // ------------------------------------------------------------------
    // Next-PC selection. Reset is applied in the register below so it
    // dominates everything here. A flush without a resolved branch is
    // meaningless and falls through to the normal priority.
    // ------------------------------------------------------------------
    logic flush_valid;
    assign flush_valid = bus.i_Flush && bus.i_ALU_isbranch;

    always_comb begin
        pc_next = pc_reg + 22'd1;
        if (flush_valid) begin
            pc_next = bus.i_ALU_outcome ? bus.i_ALU_target
                                        : (bus.i_ALU_pc + 22'd1);
        end else if (bus.i_Stall) begin
            pc_next = pc_reg;
        end else if (pred_taken) begin
            pc_next = rd_target;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            pc_reg    <= RESET_PC;
            valid_reg <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            // A stall keeps the held address live, so valid simply stays up.
            valid_reg <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.o_IMEM_address = pc_reg;
    assign bus.o_valid        = valid_reg;
    assign bus.o_pred_taken   = pred_taken;
    assign bus.o_pred_target  = rd_target;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_gen
//
// Scoreboard bench for fetch_pc_gen. The driver applies one set of inputs per
// cycle on the falling edge, predicts the outputs for that cycle from a
// behavioural model (PC as an integer, BTB as a table keyed by pc mod N that
// remembers the full trained PC), and queues the prediction. A monitor pops
// and compares shortly after each falling edge. Directed scenarios come
// first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_fetch_pc_gen;

    localparam int          N   = 16;
    localparam logic [21:0] RPC = 22'h000000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_pc_gen_if bus ();

    fetch_pc_gen #(
        .BTB_ENTRIES (N),
        .RESET_PC    (RPC)
    ) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    typedef struct {
        logic [21:0] addr;
        logic        valid;
        logic        pt;
        logic [21:0] tgt;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    // Behavioural model state
    logic [21:0] m_pc;
    bit          m_valid;
    bit          m_known = 1'b0;
    bit          m_bv   [N];
    logic [21:0] m_bpc  [N];
    logic [21:0] m_btgt [N];

    task automatic check(string name, logic [21:0] act, logic [21:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s txn=%0d actual=%h required=%h", name, n_txn, act, req);
        end
    endtask

    // Apply one cycle of inputs, queue the expected outputs, advance model.
    task automatic step(bit r, bit st, bit bp, bit fl, bit isb, bit oc,
                        logic [21:0] apc, logic [21:0] at);
        exp_t e;
        int   ci;
        int   ai;
        bit   hit;
        rst                = r;
        bus.i_Stall        = st;
        bus.i_BP_taken     = bp;
        bus.i_Flush        = fl;
        bus.i_ALU_isbranch = isb;
        bus.i_ALU_outcome  = oc;
        bus.i_ALU_pc       = apc;
        bus.i_ALU_target   = at;

        ci     = int'(m_pc % N);
        hit    = m_bv[ci] && (m_bpc[ci] == m_pc);
        e.addr = m_pc;
        e.valid = m_valid;
        e.pt   = hit && bp && !st;
        e.tgt  = hit ? m_btgt[ci] : 22'd0;
        if (m_known) sb.push_back(e);

        if (r) begin
            m_pc    = RPC;
            m_valid = 1'b0;
            m_known = 1'b1;
            for (int i = 0; i < N; i++) m_bv[i] = 1'b0;
        end else begin
            m_valid = 1'b1;
            if (fl && isb)  m_pc = oc ? at : apc + 22'd1;
            else if (!st)   m_pc = e.pt ? e.tgt : m_pc + 22'd1;
            ai = int'(apc % N);
            if (isb && oc) begin
                m_bv[ai]   = 1'b1;
                m_bpc[ai]  = apc;
                m_btgt[ai] = at;
            end
`ifdef FETCH_BTB_INVALIDATE_EN
            else if (isb && !oc && m_bv[ai] && m_bpc[ai] == apc) begin
                m_bv[ai] = 1'b0;
            end
`endif
        end
        @(negedge clk);
    endtask

    // Monitor: compare every cycle for which an expectation was queued.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_txn++;
                check("addr",   bus.o_IMEM_address,      e.addr);
                check("valid",  22'(bus.o_valid),        22'(e.valid));
                check("pred",   22'(bus.o_pred_taken),   22'(e.pt));
                check("target", bus.o_pred_target,       e.tgt);
                $display("txn %0d addr=%h valid=%b pred=%b tgt=%h",
                         n_txn, bus.o_IMEM_address, bus.o_valid,
                         bus.o_pred_taken, bus.o_pred_target);
            end
        end
    end

    initial begin
        bit          r, st, bp, fl, isb, oc;
        logic [21:0] apc, at;

        rst = 1'b1;
        bus.i_Stall = 1'b0;  bus.i_BP_taken = 1'b0; bus.i_Flush = 1'b0;
        bus.i_ALU_isbranch = 1'b0; bus.i_ALU_outcome = 1'b0;
        bus.i_ALU_pc = '0;   bus.i_ALU_target = '0;
        @(negedge clk);

        // Reset then idle: addresses 0,1,2,3 with valid 0 then 1.
        step(1, 0, 0, 0, 0, 0, 22'h0, 22'h0);
        step(0, 0, 0, 0, 0, 0, 22'h0, 22'h0);
        step(0, 0, 0, 0, 0, 0, 22'h0, 22'h0);
        step(0, 0, 0, 0, 1, 1, 22'h4, 22'h100);   // train 4 -> 0x100
        step(0, 0, 0, 0, 0, 0, 22'h0, 22'h0);
        step(0, 0, 1, 0, 0, 0, 22'h0, 22'h0);     // PC 4 hit, taken -> 0x100
        step(0, 0, 0, 1, 1, 1, 22'h50, 22'h4);    // flush back to 4
        step(0, 0, 0, 0, 0, 0, 22'h0, 22'h0);     // PC 4, bp=0 -> 5
        step(0, 1, 0, 1, 1, 0, 22'h4, 22'h0);     // flush+stall, not taken -> 5
        step(0, 0, 0, 1, 1, 1, 22'h4, 22'h200);   // flush taken -> 0x200
        // Aliasing on index 4
        step(0, 0, 0, 0, 1, 1, 22'h4, 22'h100);
        step(0, 0, 0, 0, 1, 1, 22'h14, 22'h300);
        step(0, 0, 0, 1, 1, 1, 22'h60, 22'h4);
        step(0, 0, 1, 0, 0, 0, 22'h0, 22'h0);     // PC 4 misses -> 5
        step(0, 0, 0, 0, 0, 0, 22'h0, 22'h0);
        // Wrap
        step(0, 0, 0, 1, 1, 1, 22'h61, 22'h3FFFFF);
        step(0, 0, 1, 0, 0, 0, 22'h0, 22'h0);     // 0x3FFFFF -> 0
        step(0, 0, 0, 0, 0, 0, 22'h0, 22'h0);
        // Not-taken resolution of a trained branch
        step(0, 0, 0, 0, 1, 1, 22'h4, 22'h100);
        step(0, 0, 0, 0, 1, 0, 22'h4, 22'h0);
        step(0, 0, 0, 1, 1, 1, 22'h62, 22'h4);
        step(0, 0, 1, 0, 0, 0, 22'h0, 22'h0);
        step(0, 0, 0, 0, 0, 0, 22'h0, 22'h0);

        // Randomized traffic in a small address window so the BTB hits often.
        for (int k = 0; k < 2500; k++) begin
            r   = ($urandom_range(0, 199) == 0);
            st  = ($urandom_range(0, 4) == 0);
            bp  = ($urandom_range(0, 9) < 7);
            isb = ($urandom_range(0, 2) == 0);
            oc  = $urandom_range(0, 1) == 1;
            fl  = isb ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
            apc = ($urandom_range(0, 9) == 0) ? 22'($urandom) : 22'($urandom_range(0, 47));
            at  = ($urandom_range(0, 29) == 0) ? 22'h3FFFFF - 22'($urandom_range(0, 3))
                                               : 22'($urandom_range(0, 47));
            step(r, st, bp, fl, isb, oc, apc, at);
        end

        #3;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain actual=%0d pending required=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
